regfile_multiport: RTL and testbench

REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

---
 rtl/regfile_multiport.sv | 92 +++++++++
 tb/tb_regfile_multiport.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// Multi-port register file: two write ports, two read ports.
// Optional hardwired-zero register, same-cycle write forwarding to reads,
// and an optional registered read stage with one cycle of latency.
module regfile_multiport #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_EN  = 1,
  parameter int ZERO_IDX = 31,
  parameter int BYPASS   = 1,
  parameter int READ_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en0,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [DATA_W-1:0] wr_data1,
  output logic              wr_conflict
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_EN != 0) && (a == ADDR_W'(ZERO_IDX));
  endfunction

  // Read value of address a as seen this cycle: stored contents, optionally
  // overridden by same-cycle write data (port 1 last so it wins), and forced
  // to zero for the hardwired register.
  function automatic logic [DATA_W-1:0] fwd(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = mem[a];
    if (BYPASS != 0) begin
      if (wr_en0 && (wr_addr0 == a)) v = wr_data0;
      if (wr_en1 && (wr_addr1 == a)) v = wr_data1;
    end
    if (is_zero(a)) v = '0;
    return v;
  endfunction

  // Register array: async reset, sync clear, then both write ports.
  // The port 1 assignment comes second so it overrides port 0 on a shared address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i[ADDR_W-1:0]] <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i[ADDR_W-1:0]] <= '0;
    end else begin
      if (wr_en0 && !is_zero(wr_addr0)) mem[wr_addr0] <= wr_data0;
      if (wr_en1 && !is_zero(wr_addr1)) mem[wr_addr1] <= wr_data1;
    end
  end

  // Conflict flag: both ports writing the same writable register.
  always_comb begin
    wr_conflict = wr_en0 && wr_en1 && (wr_addr0 == wr_addr1) && !is_zero(wr_addr0);
  end

  generate
    if (READ_REG != 0) begin : g_rd_reg
      // Registered read: post-write value (with bypass) captured at the edge; clear forces zero.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rd_data1 <= '0;
          rd_data2 <= '0;
        end else if (clear) begin
          rd_data1 <= '0;
          rd_data2 <= '0;
        end else begin
          rd_data1 <= fwd(rd_addr1);
          rd_data2 <= fwd(rd_addr2);
        end
      end
    end else begin : g_rd_comb
      // Combinational read straight from address (clear is not visible until the edge).
      always_comb begin
        rd_data1 = fwd(rd_addr1);
        rd_data2 = fwd(rd_addr2);
      end
    end
  endgenerate

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport. Four instances share one stimulus
// stream: combinational read with/without bypass, registered read with/without
// bypass. A reference array model predicts every read and the conflict flag.
module tb_regfile_multiport;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic [4:0]  rd_addr1 = '0, rd_addr2 = '0, wr_addr0 = '0, wr_addr1 = '0;
  logic        wr_en0 = 1'b0, wr_en1 = 1'b0;
  logic [63:0] wr_data0 = '0, wr_data1 = '0;

  logic [63:0] c_rd1, c_rd2, n_rd1, n_rd2, r_rd1, r_rd2, q_rd1, q_rd2;
  logic        c_cf, n_cf, r_cf, q_cf;

  always #5 clk = ~clk;

  regfile_multiport #(.DATA_W(64), .ADDR_W(5), .ZERO_EN(1), .ZERO_IDX(31), .BYPASS(1), .READ_REG(0)) u_comb (
    .clk(clk), .rst(rst), .clear(clear), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(c_rd1), .rd_data2(c_rd2), .wr_en0(wr_en0), .wr_en1(wr_en1),
    .wr_addr0(wr_addr0), .wr_addr1(wr_addr1), .wr_data0(wr_data0), .wr_data1(wr_data1),
    .wr_conflict(c_cf));

  regfile_multiport #(.DATA_W(64), .ADDR_W(5), .ZERO_EN(1), .ZERO_IDX(31), .BYPASS(0), .READ_REG(0)) u_nobyp (
    .clk(clk), .rst(rst), .clear(clear), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(n_rd1), .rd_data2(n_rd2), .wr_en0(wr_en0), .wr_en1(wr_en1),
    .wr_addr0(wr_addr0), .wr_addr1(wr_addr1), .wr_data0(wr_data0), .wr_data1(wr_data1),
    .wr_conflict(n_cf));

  regfile_multiport #(.DATA_W(64), .ADDR_W(5), .ZERO_EN(1), .ZERO_IDX(31), .BYPASS(1), .READ_REG(1)) u_reg (
    .clk(clk), .rst(rst), .clear(clear), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(r_rd1), .rd_data2(r_rd2), .wr_en0(wr_en0), .wr_en1(wr_en1),
    .wr_addr0(wr_addr0), .wr_addr1(wr_addr1), .wr_data0(wr_data0), .wr_data1(wr_data1),
    .wr_conflict(r_cf));

  regfile_multiport #(.DATA_W(64), .ADDR_W(5), .ZERO_EN(1), .ZERO_IDX(31), .BYPASS(0), .READ_REG(1)) u_regnb (
    .clk(clk), .rst(rst), .clear(clear), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(q_rd1), .rd_data2(q_rd2), .wr_en0(wr_en0), .wr_en1(wr_en1),
    .wr_addr0(wr_addr0), .wr_addr1(wr_addr1), .wr_data0(wr_data0), .wr_data1(wr_data1),
    .wr_conflict(q_cf));

  int vectors = 0;
  int miscompares = 0;

  // Reference contents of the register file (index 31 is the zero register).
  logic [63:0] mem [32];

  typedef struct { logic [63:0] c1, c2, n1, n2; logic cf; } cexp_t;
  typedef struct { logic [63:0] r1, r2, q1, q2; } rexp_t;
  cexp_t qc[$];
  rexp_t qr[$];
  event  ev_c;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Combinational outputs: checked shortly after each stimulus is applied.
  initial begin
    cexp_t e;
    forever begin
      @(ev_c);
      #1;
      if (qc.size() == 0) begin
        miscompares++;
        $display("FAIL comb_underflow: got empty queue expected entry");
      end else begin
        e = qc.pop_front();
        chk("comb_rd1",   c_rd1, e.c1);
        chk("comb_rd2",   c_rd2, e.c2);
        chk("nobyp_rd1",  n_rd1, e.n1);
        chk("nobyp_rd2",  n_rd2, e.n2);
        chk("conf_comb",  64'(c_cf), 64'(e.cf));
        chk("conf_nobyp", 64'(n_cf), 64'(e.cf));
        chk("conf_reg",   64'(r_cf), 64'(e.cf));
        chk("conf_regnb", 64'(q_cf), 64'(e.cf));
      end
    end
  end

  // Registered outputs: checked just after the edge that captured them.
  initial begin
    rexp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qr.size() > 0) begin
        e = qr.pop_front();
        chk("reg_rd1",   r_rd1, e.r1);
        chk("reg_rd2",   r_rd2, e.r2);
        chk("regnb_rd1", q_rd1, e.q1);
        chk("regnb_rd2", q_rd2, e.q2);
      end
    end
  end

  // One clock of stimulus; predicts every output from the reference array.
  task automatic cycle(input logic e0, input logic [4:0] a0, input logic [63:0] d0,
                       input logic e1, input logic [4:0] a1, input logic [63:0] d1,
                       input logic [4:0] ra1, input logic [4:0] ra2, input logic clr);
    logic [63:0] wrd [32];
    logic [63:0] post [32];
    cexp_t ce;
    rexp_t re;
    @(negedge clk);
    wr_en0 = e0; wr_addr0 = a0; wr_data0 = d0;
    wr_en1 = e1; wr_addr1 = a1; wr_data1 = d1;
    rd_addr1 = ra1; rd_addr2 = ra2; clear = clr;
    #1;
    wrd = mem;
    if (e0) wrd[a0] = d0;
    if (e1) wrd[a1] = d1;
    wrd[31] = '0;
    for (int i = 0; i < 32; i++) post[i] = clr ? 64'h0 : wrd[i];
    ce.c1 = wrd[ra1]; ce.c2 = wrd[ra2];
    ce.n1 = mem[ra1]; ce.n2 = mem[ra2];
    ce.cf = e0 && e1 && (a0 == a1) && (a0 != 5'd31);
    re.r1 = post[ra1]; re.r2 = post[ra2];
    re.q1 = clr ? 64'h0 : mem[ra1];
    re.q2 = clr ? 64'h0 : mem[ra2];
    qc.push_back(ce);
    -> ev_c;
    qr.push_back(re);
    @(posedge clk);
    mem = post;
  endtask

  // Asynchronous reset between edges after registers 0 and 31 were written.
  task automatic mid_reset();
    @(negedge clk);
    wr_en0 = 1'b0; wr_en1 = 1'b0; clear = 1'b0;
    rd_addr1 = 5'd0; rd_addr2 = 5'd31;
    #3;
    chk("pre_rst_rd1", c_rd1, mem[0]);
    rst = 1'b0;
    #1;
    chk("arst_comb_rd1",  c_rd1, 64'h0);
    chk("arst_comb_rd2",  c_rd2, 64'h0);
    chk("arst_nobyp_rd1", n_rd1, 64'h0);
    chk("arst_reg_rd1",   r_rd1, 64'h0);
    chk("arst_reg_rd2",   r_rd2, 64'h0);
    chk("arst_regnb_rd1", q_rd1, 64'h0);
    qr.delete();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_reg_rd1",   r_rd1, 64'h0);
    chk("rst_regnb_rd2", q_rd2, 64'h0);
    rst = 1'b1;

    // Reset state: unwritten registers read zero
    cycle(0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 5'd0, 5'd5, 0);
    // Write then read back addr 0
    cycle(1, 5'd0, 64'h1FFF_FFFF_FFFF_FFF8, 0, 5'd0, 64'h0, 5'd1, 5'd2, 0);
    cycle(0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 5'd0, 5'd1, 0);
    // Dual write to 7: conflict, port 1 wins
    cycle(1, 5'd7, 64'hAAAA, 1, 5'd7, 64'h5555, 5'd7, 5'd0, 0);
    cycle(0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 5'd7, 5'd7, 0);
    // Zero register: no conflict, reads zero
    cycle(1, 5'd31, 64'hF000_0000_0000_000F, 1, 5'd31, 64'hF000_0000_0000_000F, 5'd31, 5'd31, 0);
    cycle(0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 5'd31, 5'd7, 0);
    // Bypass on read port 2
    cycle(1, 5'd3, 64'h1234, 0, 5'd0, 64'h0, 5'd0, 5'd3, 0);
    // Registered-read latency and bypass
    cycle(1, 5'd5, 64'h99, 0, 5'd0, 64'h0, 5'd3, 5'd3, 0);
    cycle(0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 5'd5, 5'd0, 0);
    cycle(1, 5'd5, 64'h77, 0, 5'd0, 64'h0, 5'd5, 5'd5, 0);
    // Port 0 only vs port 1 to different addresses
    cycle(1, 5'd9, 64'hDEAD, 1, 5'd10, 64'hBEEF, 5'd9, 5'd10, 0);
    // Clear with pending write to addr 2
    cycle(1, 5'd2, 64'hCAFE, 0, 5'd0, 64'h0, 5'd2, 5'd5, 1);
    cycle(0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 5'd2, 5'd5, 0);
    // Write regs 0 and 31, then async reset
    cycle(1, 5'd0, 64'h0123_4567_89AB_CDEF, 1, 5'd31, 64'h1111, 5'd0, 5'd31, 0);
    cycle(0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 5'd0, 5'd31, 0);
    mid_reset();
    // First write after release is accepted
    cycle(1, 5'd4, 64'h4444, 0, 5'd0, 64'h0, 5'd4, 5'd0, 0);
    cycle(0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 5'd4, 5'd0, 0);

    // Randomized traffic biased toward address collisions
    for (int n = 0; n < 400; n++) begin
      logic e0, e1, clr;
      logic [4:0] a0, a1, ra1, ra2;
      logic [63:0] d0, d1;
      e0  = 1'($urandom_range(0, 1));
      e1  = 1'($urandom_range(0, 1));
      a0  = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      a1  = ($urandom_range(0, 2) == 0) ? a0 : 5'($urandom_range(0, 7));
      ra1 = ($urandom_range(0, 2) == 0) ? a0 : 5'($urandom_range(0, 7));
      ra2 = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 31));
      d0  = {$urandom, $urandom};
      d1  = {$urandom, $urandom};
      clr = ($urandom_range(0, 19) == 0);
      cycle(e0, a0, d0, e1, a1, d1, ra1, ra2, clr);
    end

    repeat (2) @(negedge clk);
    if (qc.size() != 0 || qr.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", qc.size(), qr.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
